// File: rtl/fifo_control_pkg.sv
// fifo_control_pkg: shared sizes, frame length and state encoding for the FFT frame buffer and serial sender
package fifo_control_pkg;
  localparam int DATA_W = 14;
  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam int FRAME_LEN = 16;
  typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: single-clock DEPTH x DATA_W RAM with one write port and one registered read port
module fifo_sync_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_control_0.sv
// fifo_control_0: captures one FFT frame into a FIFO and serialises it out paced by rd_tick and gated by rx_ready
module fifo_control_0 #(
  parameter int DATA_W = fifo_control_pkg::DATA_W,
  parameter int DEPTH = fifo_control_pkg::DEPTH,
  parameter int ADDR_W = fifo_control_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_tick,
  input  logic              data_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] data_re,
  output logic              tx_ready,
  output logic              data_out
);
  import fifo_control_pkg::*;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] STOP = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  state_t state;
  logic dv_q, active, rise, we;
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0] shreg, rdata;
  assign rise = data_valid && !dv_q;
  assign we = (state == IDLE && rise && rx_ready) || (state == FILL && data_valid);
  fifo_sync_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(data_re),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dv_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bit_cnt <= '0;
      active <= 1'b0;
      shreg <= '0;
      tx_ready <= 1'b0;
      data_out <= 1'b1;
    end else begin
      dv_q <= data_valid;
      case (state)
        IDLE: if (rise && rx_ready) begin
          wr_ptr <= (ADDR_W + 1)'(1);
          state <= FILL;
        end
        FILL: if (!data_valid) begin
          wr_ptr <= '0;
          state <= IDLE;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST) state <= SEND;
        end
        SEND: if (rd_tick) begin
          if (!active || bit_cnt == STOP) begin
            if (rd_ptr == FULL) begin
              state <= IDLE;
              wr_ptr <= '0;
              rd_ptr <= '0;
              bit_cnt <= '0;
              active <= 1'b0;
              tx_ready <= 1'b0;
              data_out <= 1'b1;
            end else if (rx_ready) begin
              data_out <= 1'b0;
              shreg <= rdata;
              rd_ptr <= rd_ptr + 1'b1;
              bit_cnt <= '0;
              active <= 1'b1;
              tx_ready <= 1'b1;
            end else begin
              active <= 1'b0;
              tx_ready <= 1'b0;
              data_out <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            data_out <= (int'(bit_cnt) < DATA_W) ? shreg[0] : 1'b1;
            shreg <= shreg >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_control_0.sv
// tb_fifo_control_0: scoreboard bench decoding the serial line against captured frame data
module tb_fifo_control_0;
  localparam int DW = 14;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_tick = 1'b0;
  logic data_valid = 1'b0;
  logic rx_ready = 1'b0;
  logic [DW-1:0] data_re = '0;
  logic tx_ready, data_out;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  fifo_control_0 #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .rd_tick(rd_tick),
    .data_valid(data_valid),
    .rx_ready(rx_ready),
    .data_re(data_re),
    .tx_ready(tx_ready),
    .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input int n, input int base, input bit push);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_re = DW'(base + i);
      if (push) q.push_back(DW'(base + i));
      step();
    end
    data_valid = 1'b0;
    step();
  endtask
  task automatic tick(input int gap, output logic b, output logic t);
    rd_tick = 1'b1;
    step();
    rd_tick = 1'b0;
    b = data_out;
    t = tx_ready;
    repeat (gap - 1) step();
  endtask
  task automatic recv_word(input int gap, input int drop_at, output logic [15:0] f, output logic txa);
    logic b, t;
    txa = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(gap, b, t);
      f[i] = b;
      txa = txa & t;
      if (i == drop_at) rx_ready = 1'b0;
    end
  endtask
  task automatic test_reset();
    logic b, t;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_valid = i[0];
      rx_ready = ~i[0];
      rd_tick = 1'b1;
      data_re = DW'(i * 77);
      step();
      checks++;
      if (data_out !== 1'b1 || tx_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset cycle %0d: data_out=%b tx_ready=%b, want 1/0", i, data_out, tx_ready);
      end
    end
    rst = 1'b0;
    data_valid = 1'b0;
    rd_tick = 1'b0;
    rx_ready = 1'b1;
    step();
    tick(3, b, t);
    checks++;
    if (b !== 1'b1 || t !== 1'b0) begin
      failures++;
      $display("FAIL reset idle: data_out=%b tx_ready=%b, want 1/0", b, t);
    end
    rx_ready = 1'b0;
  endtask
  task automatic test_capture_gating();
    logic b, t, ok;
    rx_ready = 1'b0;
    burst(DEPTH, 1000, 1'b0);
    rx_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(3, b, t);
      if (b !== 1'b1 || t !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL gating: line active after gated burst, want data_out=1 tx_ready=0");
    end
    burst(DEPTH, 0, 1'b1);
  endtask
  task automatic test_full_frame();
    logic [15:0] f;
    logic txa, b, t;
    logic [DW-1:0] w;
    rx_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      recv_word(11, -1, f, txa);
      w = q.pop_front();
      checks++;
      if (f !== {1'b1, w, 1'b0} || txa !== 1'b1) begin
        failures++;
        $display("FAIL full_frame word %0d: frame=%h tx_ready=%b, want frame=%h tx_ready=1", k, f, txa, {1'b1, w, 1'b0});
      end
    end
    tick(11, b, t);
    checks++;
    if (b !== 1'b1 || t !== 1'b0) begin
      failures++;
      $display("FAIL full_frame end: data_out=%b tx_ready=%b, want 1/0", b, t);
    end
  endtask
  task automatic test_pause_resume();
    logic [15:0] f;
    logic txa, b, t, ok;
    logic [DW-1:0] w;
    rx_ready = 1'b1;
    burst(DEPTH, 100, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      recv_word(3, (k == 30) ? 5 : -1, f, txa);
      w = q.pop_front();
      checks++;
      if (f !== {1'b1, w, 1'b0} || txa !== 1'b1) begin
        failures++;
        $display("FAIL pause word %0d: frame=%h tx_ready=%b, want frame=%h tx_ready=1", k, f, txa, {1'b1, w, 1'b0});
      end
      if (k == 30) begin
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
          tick(3, b, t);
          if (b !== 1'b1 || t !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
          failures++;
          $display("FAIL pause hold: line not idle while rx_ready low, want data_out=1 tx_ready=0");
        end
        rx_ready = 1'b1;
      end
    end
    tick(3, b, t);
    checks++;
    if (b !== 1'b1 || t !== 1'b0) begin
      failures++;
      $display("FAIL pause end: data_out=%b tx_ready=%b, want 1/0", b, t);
    end
  endtask
  task automatic test_short_burst();
    logic [15:0] f;
    logic txa, b, t, ok;
    logic [DW-1:0] w;
    rx_ready = 1'b1;
    burst(DEPTH / 2, 200, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(3, b, t);
      if (b !== 1'b1 || t !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL short_burst: transmission after discarded frame, want data_out=1 tx_ready=0");
    end
    burst(DEPTH, 300, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      recv_word(3, -1, f, txa);
      w = q.pop_front();
      checks++;
      if (f !== {1'b1, w, 1'b0} || txa !== 1'b1) begin
        failures++;
        $display("FAIL short_burst word %0d: frame=%h tx_ready=%b, want frame=%h tx_ready=1", k, f, txa, {1'b1, w, 1'b0});
      end
    end
    tick(3, b, t);
    checks++;
    if (b !== 1'b1 || t !== 1'b0) begin
      failures++;
      $display("FAIL short_burst end: data_out=%b tx_ready=%b, want 1/0", b, t);
    end
  endtask
  task automatic test_reset_mid_send();
    logic [15:0] f;
    logic txa, b, t;
    logic [DW-1:0] w;
    rx_ready = 1'b1;
    burst(DEPTH, 400, 1'b1);
    for (int k = 0; k < 10; k++) begin
      recv_word(2, -1, f, txa);
      w = q.pop_front();
      checks++;
      if (f !== {1'b1, w, 1'b0} || txa !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid word %0d: frame=%h tx_ready=%b, want frame=%h tx_ready=1", k, f, txa, {1'b1, w, 1'b0});
      end
    end
    for (int i = 0; i < 3; i++) tick(2, b, t);
    rst = 1'b1;
    step();
    checks++;
    if (data_out !== 1'b1 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid reset: data_out=%b tx_ready=%b, want 1/0", data_out, tx_ready);
    end
    rst = 1'b0;
    q.delete();
    step();
    burst(DEPTH, 500, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      recv_word(2, -1, f, txa);
      w = q.pop_front();
      checks++;
      if (f !== {1'b1, w, 1'b0} || txa !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid recapture word %0d: frame=%h tx_ready=%b, want frame=%h tx_ready=1", k, f, txa, {1'b1, w, 1'b0});
      end
    end
    tick(2, b, t);
    checks++;
    if (b !== 1'b1 || t !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid end: data_out=%b tx_ready=%b, want 1/0", b, t);
    end
  endtask
  initial begin
    test_reset();
    test_capture_gating();
    test_full_frame();
    test_pause_resume();
    test_short_burst();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
